// File: rtl/pc_branch_unit.sv
// Next-PC / branch resolution stage following the ALU.
// Latches carry, resolves branches, drives link write and halt.
module pc_branch_unit #(
  parameter int          size     = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          OFS_W    = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       br_type,
  input  logic [2:0]       alu_flag,
  input  logic             flag_we,
  input  logic [OFS_W-1:0] offset,
  input  logic [size-1:0]  rs_val,
  output logic [size-1:0]  pc,
  output logic             carry_q,
  output logic             taken,
  output logic             link_we,
  output logic [size-1:0]  link_data,
  output logic             halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state;

  logic [size-1:0] seq;
  logic [size-1:0] ofs_x;
  logic [size-1:0] rel;
  logic [size-1:0] tgt;
  logic            take;
  logic            is_bl;
  logic            is_halt;

  assign seq   = pc + size'(4);
  assign ofs_x = {{(size-OFS_W){offset[OFS_W-1]}}, offset};
  assign rel   = seq + (ofs_x << 2);

  always_comb begin
    tgt     = rel;
    take    = 1'b0;
    is_bl   = 1'b0;
    is_halt = 1'b0;
    case (br_type)
      4'b0001: take = 1'b1;
      4'b0010: begin
        take = 1'b1;
        tgt  = {rs_val[size-1:2], 2'b00};
      end
      4'b0011: take = alu_flag[0];
      4'b0100: take = ~alu_flag[0];
      4'b0101: take = alu_flag[1];
      4'b0110: take = carry_q;
      4'b0111: take = ~carry_q;
      4'b1000: begin
        take  = 1'b1;
        is_bl = 1'b1;
      end
      4'b1001: is_halt = 1'b1;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      pc        <= RESET_PC[size-1:0];
      carry_q   <= 1'b0;
      taken     <= 1'b0;
      link_we   <= 1'b0;
      link_data <= '0;
      halted    <= 1'b0;
    end else begin
      taken   <= 1'b0;
      link_we <= 1'b0;
      if (state == RUN && en) begin
        // condition above already used the old carry_q
        if (flag_we)
          carry_q <= alu_flag[2];
        if (is_halt) begin
          state  <= HALT;
          halted <= 1'b1;
        end else begin
          pc    <= take ? tgt : seq;
          taken <= take;
          if (is_bl) begin
            link_data <= seq;
            link_we   <= 1'b1;
          end
        end
      end
    end
  end

endmodule
